// File: rtl/snake_seg_mem_arbiter_if.sv
// rtl/snake_seg_mem_arbiter_if.sv - game/VGA request and segment RAM bus bundle
interface snake_seg_mem_arbiter_if #(
    parameter int AW = 6,
    parameter int DW = 12
);
    logic          game_req;
    logic          game_we;
    logic [AW-1:0] game_addr;
    logic [DW-1:0] game_wdata;
    logic          game_gnt;
    logic          game_rvalid;
    logic [DW-1:0] game_rdata;
    logic          vga_req;
    logic [AW-1:0] vga_addr;
    logic          vga_gnt;
    logic          vga_rvalid;
    logic [DW-1:0] vga_rdata;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    modport slave (
        input  game_req, game_we, game_addr, game_wdata, vga_req, vga_addr, ram_rdata,
        output game_gnt, game_rvalid, game_rdata, vga_gnt, vga_rvalid, vga_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output game_req, game_we, game_addr, game_wdata, vga_req, vga_addr, ram_rdata,
        input  game_gnt, game_rvalid, game_rdata, vga_gnt, vga_rvalid, vga_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/snake_seg_mem_arbiter.sv
// rtl/snake_seg_mem_arbiter.sv - game-priority segment RAM arbiter with VGA starvation guard
module snake_seg_mem_arbiter #(
    parameter int X_BITS       = 6,
    parameter int Y_BITS       = 6,
    parameter int S_ADDR_W     = 6,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                          sys_clk,
    input  logic                          sys_reset,
    snake_seg_mem_arbiter_if.slave        bus,
    output logic [7:0]                    starve_events
);
    localparam int DW = X_BITS + Y_BITS;
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    localparam logic [0:0] ST_GAME_PRI   = 1'b0;
    localparam logic [0:0] ST_VGA_FORCED = 1'b1;

    logic [0:0]    r_state;
    logic [CW-1:0] r_starve_cnt;
    logic [7:0]    r_starve_events;
    logic          r_game_rvalid;
    logic          r_vga_rvalid;
    logic [DW-1:0] r_game_hold;
    logic [DW-1:0] r_vga_hold;

    logic          w_forced;
    logic          w_game_gnt;
    logic          w_vga_gnt;
    logic [CW-1:0] w_cnt_inc;

    always_comb begin
        w_forced   = (r_state == ST_VGA_FORCED);
        w_game_gnt = bus.game_req & ~w_forced;
        w_vga_gnt  = bus.vga_req & (w_forced | ~bus.game_req);
        w_cnt_inc  = r_starve_cnt + CW'(1);
    end

    assign bus.game_gnt  = w_game_gnt;
    assign bus.vga_gnt   = w_vga_gnt;
    assign bus.ram_en    = w_game_gnt | w_vga_gnt;
    assign bus.ram_we    = w_game_gnt & bus.game_we;
    assign bus.ram_addr  = w_game_gnt ? bus.game_addr : bus.vga_addr;
    assign bus.ram_wdata = bus.game_wdata;

    // Read data is live from the RAM in the valid cycle and held afterwards.
    assign bus.game_rvalid = r_game_rvalid;
    assign bus.game_rdata  = r_game_rvalid ? bus.ram_rdata : r_game_hold;
    assign bus.vga_rvalid  = r_vga_rvalid;
    assign bus.vga_rdata   = r_vga_rvalid ? bus.ram_rdata : r_vga_hold;
    assign starve_events   = r_starve_events;

    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            r_state         <= ST_GAME_PRI;
            r_starve_cnt    <= '0;
            r_starve_events <= '0;
            r_game_rvalid   <= 1'b0;
            r_vga_rvalid    <= 1'b0;
            r_game_hold     <= '0;
            r_vga_hold      <= '0;
        end else begin
            r_game_rvalid <= w_game_gnt & ~bus.game_we;
            r_vga_rvalid  <= w_vga_gnt;
            if (r_game_rvalid) r_game_hold <= bus.ram_rdata;
            if (r_vga_rvalid)  r_vga_hold  <= bus.ram_rdata;

            case (r_state)
                ST_GAME_PRI: begin
                    if (w_vga_gnt) begin
                        r_starve_cnt <= '0;
                    end else if (w_game_gnt && bus.vga_req) begin
                        r_starve_cnt <= w_cnt_inc;
                        // Move on the grant that reaches the limit so the next slot is VGA's.
                        if (w_cnt_inc == CW'(STARVE_LIMIT)) r_state <= ST_VGA_FORCED;
                    end
                end
                default: begin
                    r_starve_cnt <= '0;
                    r_state      <= ST_GAME_PRI;
                    if (r_starve_events != 8'hFF) r_starve_events <= r_starve_events + 8'd1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_snake_seg_mem_arbiter.sv
// tb/tb_snake_seg_mem_arbiter.sv - directed self-checking bench for snake_seg_mem_arbiter
module tb_snake_seg_mem_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] starve_events;
    int         errs = 0;
    int         checks = 0;

    snake_seg_mem_arbiter_if #(.AW(6), .DW(12)) bus ();

    snake_seg_mem_arbiter #(
        .X_BITS(6), .Y_BITS(6), .S_ADDR_W(6), .STARVE_LIMIT(4)
    ) dut (
        .sys_clk       (clk),
        .sys_reset     (rst),
        .bus           (bus),
        .starve_events (starve_events)
    );

    always #5 clk = ~clk;

    logic [11:0] mem [64];
    logic        preloaded = 1'b0;
    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < 64; i++) mem[i] <= 12'h000;
            mem[0] <= 12'h111;
            mem[1] <= 12'h222;
            mem[2] <= 12'h333;
            mem[3] <= 12'h444;
            mem[5] <= {6'd10, 6'd20};
            preloaded <= 1'b1;
        end else if (bus.ram_en) begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            else            bus.ram_rdata     <= mem[bus.ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [11:0] vexp [4];
        vexp[0] = 12'h111; vexp[1] = 12'h222; vexp[2] = 12'h333; vexp[3] = 12'h444;
        bus.game_req = 0; bus.game_we = 0; bus.game_addr = 0; bus.game_wdata = 0;
        bus.vga_req = 0; bus.vga_addr = 0;
        repeat (3) tick();
        chk("rst_game_gnt", 32'(bus.game_gnt), 0);
        chk("rst_ram_en", 32'(bus.ram_en), 0);
        chk("rst_game_rvalid", 32'(bus.game_rvalid), 0);
        chk("rst_vga_rvalid", 32'(bus.vga_rvalid), 0);
        chk("rst_vga_rdata", 32'(bus.vga_rdata), 0);
        chk("rst_starve_events", 32'(starve_events), 0);
        rst = 0;
        tick();

        bus.game_req = 1; bus.game_we = 0; bus.game_addr = 6'd5;
        #1;
        chk("g_rd_gnt", 32'(bus.game_gnt), 1);
        chk("g_rd_ram_addr", 32'(bus.ram_addr), 5);
        chk("g_rd_ram_we", 32'(bus.ram_we), 0);
        tick();
        bus.game_req = 0;
        chk("g_rd_rvalid", 32'(bus.game_rvalid), 1);
        chk("g_rd_rdata", 32'(bus.game_rdata), 32'h294);
        tick();
        chk("g_rd_rvalid_drop", 32'(bus.game_rvalid), 0);

        for (int i = 0; i <= 4; i++) begin
            if (i < 4) begin
                bus.vga_req = 1; bus.vga_addr = 6'(i);
                #1;
                chk("v_gnt", 32'(bus.vga_gnt), 1);
            end else begin
                bus.vga_req = 0;
            end
            if (i > 0) begin
                chk("v_rvalid", 32'(bus.vga_rvalid), 1);
                chk("v_rdata", 32'(bus.vga_rdata), 32'(vexp[i-1]));
            end
            tick();
        end
        chk("v_rvalid_drop", 32'(bus.vga_rvalid), 0);
        chk("v_rdata_hold", 32'(bus.vga_rdata), 32'h444);

        bus.game_req = 1; bus.game_we = 1; bus.game_addr = 6'd7; bus.game_wdata = 12'hABC;
        bus.vga_req = 1; bus.vga_addr = 6'd7;
        #1;
        chk("wr_game_gnt", 32'(bus.game_gnt), 1);
        chk("wr_vga_blocked", 32'(bus.vga_gnt), 0);
        chk("wr_ram_we", 32'(bus.ram_we), 1);
        tick();
        bus.game_req = 0; bus.game_we = 0;
        chk("wr_no_rvalid", 32'(bus.game_rvalid), 0);
        #1;
        chk("raw_vga_gnt", 32'(bus.vga_gnt), 1);
        tick();
        bus.vga_req = 0;
        chk("raw_vga_rdata", 32'(bus.vga_rdata), 32'hABC);
        tick();

        bus.game_req = 1; bus.game_we = 0; bus.game_addr = 6'd5;
        bus.vga_req = 1; bus.vga_addr = 6'd0;
        for (int c = 0; c < 15; c++) begin
            #1;
            chk("starve_vga_gnt", 32'(bus.vga_gnt), (c % 5 == 4) ? 1 : 0);
            chk("starve_game_gnt", 32'(bus.game_gnt), (c % 5 == 4) ? 0 : 1);
            tick();
        end
        chk("starve_events_3", 32'(starve_events), 3);
        repeat (1255) tick();
        chk("starve_events_254", 32'(starve_events), 254);
        repeat (10) tick();
        chk("starve_events_sat", 32'(starve_events), 255);
        bus.game_req = 0;
        tick();

        bus.vga_addr = 6'd1;
        #1;
        chk("rst_mid_vga_gnt", 32'(bus.vga_gnt), 1);
        tick();
        bus.vga_req = 0;
        rst = 1;
        #1;
        chk("rst_mid_vga_rvalid", 32'(bus.vga_rvalid), 0);
        chk("rst_mid_vga_rdata", 32'(bus.vga_rdata), 0);
        chk("rst_mid_starve_events", 32'(starve_events), 0);
        tick();
        rst = 0;
        tick();
        chk("post_rst_vga_rvalid", 32'(bus.vga_rvalid), 0);
        chk("post_rst_ram_en", 32'(bus.ram_en), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
